// File: rtl/mem2_stage.sv
// mem2_stage: second memory stage, collects the load response and
// formats it into a byte-enabled register write for ws.
module mem2_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        m1s_to_m2s_valid,
   output logic        m2s_allowin,
   input  logic [31:0] m1s_pc,
   input  logic [4:0]  m1s_rd,
   input  logic        m1s_reg_write,
   input  logic [2:0]  m1s_load_op,
   input  logic [1:0]  m1s_addr_lo,
   input  logic [31:0] m1s_result,
   input  logic [31:0] m1s_rt_val,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   input  logic        flush,
   input  logic        ws_allowin,
   output logic        m2s_to_ws_valid,
   output logic [31:0] m2s_pc,
   output logic [4:0]  m2s_rd,
   output logic        m2s_reg_write,
   output logic [3:0]  m2s_rf_wen,
   output logic [31:0] m2s_wdata,
   output logic        m2s_valid,
   output logic        m2s_fwd_ok
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_WAIT  = 2'd1,
      S_FULL  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LBU  = 3'd2;
   localparam logic [2:0] LD_LH   = 3'd3;
   localparam logic [2:0] LD_LHU  = 3'd4;
   localparam logic [2:0] LD_LW   = 3'd5;
   localparam logic [2:0] LD_LWL  = 3'd6;
   localparam logic [2:0] LD_LWR  = 3'd7;

   state_t      state, state_nxt;
   logic        reg_write_q;
   logic [2:0]  load_op_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] rt_val_q;
   logic        accept;
   logic        resp;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] fmt_data;
   logic [3:0]  fmt_wen;

   assign m2s_allowin = !reset &&
      (state == S_EMPTY || (state == S_FULL && ws_allowin));
   assign accept = m1s_to_m2s_valid && m2s_allowin && !flush;
   assign resp   = (state == S_WAIT) && data_data_ok && !flush;

   always_comb begin
      state_nxt = state;
      if (flush) begin
         unique case (state)
            S_EMPTY: state_nxt = S_EMPTY;
            S_FULL:  state_nxt = S_EMPTY;
            S_WAIT:  state_nxt = data_data_ok ? S_EMPTY : S_DRAIN;
            S_DRAIN: state_nxt = data_data_ok ? S_EMPTY : S_DRAIN;
            default: state_nxt = S_EMPTY;
         endcase
      end else begin
         unique case (state)
            S_EMPTY: begin
               if (accept)
                  state_nxt = (m1s_load_op != LD_NONE) ? S_WAIT : S_FULL;
            end
            S_FULL: begin
               if (accept)
                  state_nxt = (m1s_load_op != LD_NONE) ? S_WAIT : S_FULL;
               else if (ws_allowin)
                  state_nxt = S_EMPTY;
            end
            S_WAIT: begin
               if (data_data_ok)
                  state_nxt = S_FULL;
            end
            S_DRAIN: begin
               if (data_data_ok)
                  state_nxt = S_EMPTY;
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   assign ld_byte = data_rdata[{addr_lo_q, 3'b000} +: 8];
   assign ld_half = data_rdata[{addr_lo_q[1], 4'b0000} +: 16];

   // lwl/lwr merge the unaligned word with the old rt value
   always_comb begin
      fmt_data = data_rdata;
      fmt_wen  = 4'b1111;
      unique case (load_op_q)
         LD_LB:  fmt_data = {{24{ld_byte[7]}}, ld_byte};
         LD_LBU: fmt_data = {24'h0, ld_byte};
         LD_LH:  fmt_data = {{16{ld_half[15]}}, ld_half};
         LD_LHU: fmt_data = {16'h0, ld_half};
         LD_LW:  fmt_data = data_rdata;
         LD_LWL: begin
            unique case (addr_lo_q)
               2'd0: begin
                  fmt_data = {data_rdata[7:0], rt_val_q[23:0]};
                  fmt_wen  = 4'b1000;
               end
               2'd1: begin
                  fmt_data = {data_rdata[15:0], rt_val_q[15:0]};
                  fmt_wen  = 4'b1100;
               end
               2'd2: begin
                  fmt_data = {data_rdata[23:0], rt_val_q[7:0]};
                  fmt_wen  = 4'b1110;
               end
               default: begin
                  fmt_data = data_rdata;
                  fmt_wen  = 4'b1111;
               end
            endcase
         end
         LD_LWR: begin
            unique case (addr_lo_q)
               2'd0: begin
                  fmt_data = data_rdata;
                  fmt_wen  = 4'b1111;
               end
               2'd1: begin
                  fmt_data = {rt_val_q[31:24], data_rdata[31:8]};
                  fmt_wen  = 4'b0111;
               end
               2'd2: begin
                  fmt_data = {rt_val_q[31:16], data_rdata[31:16]};
                  fmt_wen  = 4'b0011;
               end
               default: begin
                  fmt_data = {rt_val_q[31:8], data_rdata[31:24]};
                  fmt_wen  = 4'b0001;
               end
            endcase
         end
         default: begin
            fmt_data = data_rdata;
            fmt_wen  = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_EMPTY;
         m2s_pc      <= 32'h0;
         m2s_rd      <= 5'h0;
         reg_write_q <= 1'b0;
         load_op_q   <= LD_NONE;
         addr_lo_q   <= 2'd0;
         rt_val_q    <= 32'h0;
         m2s_wdata   <= 32'h0;
         m2s_rf_wen  <= 4'h0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            m2s_pc      <= m1s_pc;
            m2s_rd      <= m1s_rd;
            reg_write_q <= m1s_reg_write;
            load_op_q   <= m1s_load_op;
            addr_lo_q   <= m1s_addr_lo;
            rt_val_q    <= m1s_rt_val;
            if (m1s_load_op == LD_NONE) begin
               m2s_wdata  <= m1s_result;
               m2s_rf_wen <= 4'b1111;
            end
         end else if (resp) begin
            m2s_wdata  <= fmt_data;
            m2s_rf_wen <= fmt_wen;
         end
      end
   end

   assign m2s_valid       = (state == S_WAIT) || (state == S_FULL);
   assign m2s_fwd_ok      = (state == S_FULL);
   assign m2s_to_ws_valid = (state == S_FULL);
   assign m2s_reg_write   = reg_write_q && m2s_valid;

endmodule

// File: tb/tb_mem2_stage.sv
// tb_mem2_stage: directed checks of mem2_stage handshake,
// load formatting, flush drain and async reset.
module tb_mem2_stage;

   logic        clk;
   logic        reset;
   logic        m1s_to_m2s_valid;
   logic        m2s_allowin;
   logic [31:0] m1s_pc;
   logic [4:0]  m1s_rd;
   logic        m1s_reg_write;
   logic [2:0]  m1s_load_op;
   logic [1:0]  m1s_addr_lo;
   logic [31:0] m1s_result;
   logic [31:0] m1s_rt_val;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        flush;
   logic        ws_allowin;
   logic        m2s_to_ws_valid;
   logic [31:0] m2s_pc;
   logic [4:0]  m2s_rd;
   logic        m2s_reg_write;
   logic [3:0]  m2s_rf_wen;
   logic [31:0] m2s_wdata;
   logic        m2s_valid;
   logic        m2s_fwd_ok;

   int n_assert = 0;
   int n_fail   = 0;

   mem2_stage dut (
      .clk              (clk),
      .reset            (reset),
      .m1s_to_m2s_valid (m1s_to_m2s_valid),
      .m2s_allowin      (m2s_allowin),
      .m1s_pc           (m1s_pc),
      .m1s_rd           (m1s_rd),
      .m1s_reg_write    (m1s_reg_write),
      .m1s_load_op      (m1s_load_op),
      .m1s_addr_lo      (m1s_addr_lo),
      .m1s_result       (m1s_result),
      .m1s_rt_val       (m1s_rt_val),
      .data_data_ok     (data_data_ok),
      .data_rdata       (data_rdata),
      .flush            (flush),
      .ws_allowin       (ws_allowin),
      .m2s_to_ws_valid  (m2s_to_ws_valid),
      .m2s_pc           (m2s_pc),
      .m2s_rd           (m2s_rd),
      .m2s_reg_write    (m2s_reg_write),
      .m2s_rf_wen       (m2s_rf_wen),
      .m2s_wdata        (m2s_wdata),
      .m2s_valid        (m2s_valid),
      .m2s_fwd_ok       (m2s_fwd_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [2:0] op, input logic [1:0] a,
                      input logic [4:0] rd, input logic [31:0] res,
                      input logic [31:0] rt);
      m1s_to_m2s_valid = 1'b1;
      m1s_load_op      = op;
      m1s_addr_lo      = a;
      m1s_rd           = rd;
      m1s_result       = res;
      m1s_rt_val       = rt;
      m1s_pc           = 32'h1000 + {27'h0, rd};
      m1s_reg_write    = 1'b1;
   endtask

   task automatic do_load(input string tag, input logic [2:0] op,
                          input logic [1:0] a, input logic [31:0] rt,
                          input logic [31:0] rdata,
                          input logic [31:0] exp_d,
                          input logic [3:0] exp_w);
      put(op, a, 5'd6, 32'hDEAD_BEEF, rt);
      tick();
      m1s_to_m2s_valid = 1'b0;
      chk({tag, "_wait_valid"}, {31'h0, m2s_valid}, 32'd1);
      chk({tag, "_wait_fwd"}, {31'h0, m2s_fwd_ok}, 32'd0);
      chk({tag, "_wait_ws"}, {31'h0, m2s_to_ws_valid}, 32'd0);
      data_data_ok = 1'b1;
      data_rdata   = rdata;
      tick();
      data_data_ok = 1'b0;
      chk({tag, "_ws_valid"}, {31'h0, m2s_to_ws_valid}, 32'd1);
      chk({tag, "_wdata"}, m2s_wdata, exp_d);
      chk({tag, "_wen"}, {28'h0, m2s_rf_wen}, {28'h0, exp_w});
   endtask

   initial begin
      reset = 1'b1;
      m1s_to_m2s_valid = 1'b0;
      m1s_pc = 32'h0;
      m1s_rd = 5'h0;
      m1s_reg_write = 1'b0;
      m1s_load_op = 3'd0;
      m1s_addr_lo = 2'd0;
      m1s_result = 32'h0;
      m1s_rt_val = 32'h0;
      data_data_ok = 1'b0;
      data_rdata = 32'h0;
      flush = 1'b0;
      ws_allowin = 1'b1;
      tick();
      chk("rst_allowin", {31'h0, m2s_allowin}, 32'd0);
      chk("rst_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd0);
      chk("rst_valid", {31'h0, m2s_valid}, 32'd0);
      chk("rst_fwd", {31'h0, m2s_fwd_ok}, 32'd0);
      chk("rst_regw", {31'h0, m2s_reg_write}, 32'd0);
      chk("rst_pc", m2s_pc, 32'h0);
      chk("rst_wdata", m2s_wdata, 32'h0);
      chk("rst_wen", {28'h0, m2s_rf_wen}, 32'h0);
      tick();
      reset = 1'b0;
      #1;
      chk("rel_allowin", {31'h0, m2s_allowin}, 32'd1);

      // non-load stream
      put(3'd0, 2'd0, 5'd3, 32'h11, 32'h0);
      tick();
      chk("nl0_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd1);
      chk("nl0_rd", {27'h0, m2s_rd}, 32'd3);
      chk("nl0_wdata", m2s_wdata, 32'h11);
      chk("nl0_wen", {28'h0, m2s_rf_wen}, 32'hF);
      chk("nl0_pc", m2s_pc, 32'h1003);
      chk("nl0_regw", {31'h0, m2s_reg_write}, 32'd1);
      put(3'd0, 2'd0, 5'd4, 32'h22, 32'h0);
      tick();
      chk("nl1_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd1);
      chk("nl1_rd", {27'h0, m2s_rd}, 32'd4);
      chk("nl1_wdata", m2s_wdata, 32'h22);
      put(3'd0, 2'd0, 5'd5, 32'h33, 32'h0);
      tick();
      chk("nl2_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd1);
      chk("nl2_rd", {27'h0, m2s_rd}, 32'd5);
      chk("nl2_wdata", m2s_wdata, 32'h33);
      m1s_to_m2s_valid = 1'b0;
      tick();
      chk("nl_drain", {31'h0, m2s_to_ws_valid}, 32'd0);

      // loads
      do_load("lb", 3'd1, 2'd1, 32'h0, 32'h8899AABB,
              32'hFFFFFFAA, 4'hF);
      do_load("lbu", 3'd2, 2'd3, 32'h0, 32'h8899AABB,
              32'h00000088, 4'hF);
      do_load("lh", 3'd3, 2'd2, 32'h0, 32'h8899AABB,
              32'hFFFF8899, 4'hF);
      do_load("lwl", 3'd6, 2'd1, 32'h11223344, 32'hAABBCCDD,
              32'hCCDD3344, 4'hC);
      do_load("lwr", 3'd7, 2'd2, 32'h11223344, 32'hAABBCCDD,
              32'h1122AABB, 4'h3);

      // backpressure
      ws_allowin = 1'b0;
      put(3'd0, 2'd0, 5'd7, 32'h77, 32'h0);
      #1;
      chk("bp_allowin", {31'h0, m2s_allowin}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd1);
         chk("bp_wdata", m2s_wdata, 32'h1122AABB);
         chk("bp_allowin_hold", {31'h0, m2s_allowin}, 32'd0);
      end
      ws_allowin = 1'b1;
      #1;
      chk("bp_release_allowin", {31'h0, m2s_allowin}, 32'd1);
      tick();
      m1s_to_m2s_valid = 1'b0;
      chk("bp_new_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd1);
      chk("bp_new_wdata", m2s_wdata, 32'h77);
      chk("bp_new_rd", {27'h0, m2s_rd}, 32'd7);
      tick();
      chk("bp_empty", {31'h0, m2s_valid}, 32'd0);

      // flush during WAIT, later response drained
      put(3'd5, 2'd0, 5'd8, 32'h0, 32'h0);
      tick();
      m1s_to_m2s_valid = 1'b0;
      chk("fl_wait_valid", {31'h0, m2s_valid}, 32'd1);
      chk("fl_wait_allowin", {31'h0, m2s_allowin}, 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_drain_valid", {31'h0, m2s_valid}, 32'd0);
      chk("fl_drain_allowin", {31'h0, m2s_allowin}, 32'd0);
      chk("fl_drain_regw", {31'h0, m2s_reg_write}, 32'd0);
      tick();
      chk("fl_drain_hold", {31'h0, m2s_allowin}, 32'd0);
      data_data_ok = 1'b1;
      data_rdata = 32'h12345678;
      tick();
      data_data_ok = 1'b0;
      chk("fl_done_allowin", {31'h0, m2s_allowin}, 32'd1);
      chk("fl_done_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd0);

      // flush coincident with response
      put(3'd5, 2'd0, 5'd8, 32'h0, 32'h0);
      tick();
      m1s_to_m2s_valid = 1'b0;
      flush = 1'b1;
      data_data_ok = 1'b1;
      tick();
      flush = 1'b0;
      data_data_ok = 1'b0;
      chk("flco_allowin", {31'h0, m2s_allowin}, 32'd1);
      chk("flco_valid", {31'h0, m2s_valid}, 32'd0);

      // async reset mid-FULL
      put(3'd0, 2'd0, 5'd9, 32'h99, 32'h0);
      tick();
      m1s_to_m2s_valid = 1'b0;
      ws_allowin = 1'b0;
      chk("ar_full", {31'h0, m2s_to_ws_valid}, 32'd1);
      #3;
      reset = 1'b1;
      #1;
      chk("ar_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd0);
      chk("ar_valid", {31'h0, m2s_valid}, 32'd0);
      chk("ar_fwd", {31'h0, m2s_fwd_ok}, 32'd0);
      chk("ar_regw", {31'h0, m2s_reg_write}, 32'd0);
      chk("ar_allowin", {31'h0, m2s_allowin}, 32'd0);
      chk("ar_pc", m2s_pc, 32'h0);
      chk("ar_rd", {27'h0, m2s_rd}, 32'h0);
      chk("ar_wdata", m2s_wdata, 32'h0);
      chk("ar_wen", {28'h0, m2s_rf_wen}, 32'h0);
      tick();
      reset = 1'b0;
      ws_allowin = 1'b1;
      #1;
      chk("ar_rel_allowin", {31'h0, m2s_allowin}, 32'd1);
      put(3'd0, 2'd0, 5'd10, 32'hAB, 32'h0);
      tick();
      m1s_to_m2s_valid = 1'b0;
      chk("ar_first_ws_valid", {31'h0, m2s_to_ws_valid}, 32'd1);
      chk("ar_first_wdata", m2s_wdata, 32'hAB);
      chk("ar_first_rd", {27'h0, m2s_rd}, 32'd10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem2_stage.md
# mem2_stage

Second memory stage (m2s) of the dual pipeline, between m1s and ws. It holds one instruction, collects the data-SRAM load response and aligns/extends it into a register write with byte enables. It presents that write to ws, and presents its destination and valid state to the forwarding unit, which selects the M2S and WB bypass sources.

## Interface
Parameters: none. Load-op encoding is fixed: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwl, 7 lwr.

- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- m1s_to_m2s_valid  in  1  m1s holds a valid instruction for m2s
- m2s_allowin  out  1  m2s accepts this cycle
- m1s_pc  in  32  instruction PC
- m1s_rd  in  5  destination register
- m1s_reg_write  in  1  instruction writes the GPR file
- m1s_load_op  in  3  load type per encoding above
- m1s_addr_lo  in  2  effective address [1:0]
- m1s_result  in  32  ALU/move result (non-load write data)
- m1s_rt_val  in  32  old rt value, merged for lwl/lwr
- data_data_ok  in  1  load response valid, one per issued request, in order
- data_rdata  in  32  load response word
- flush  in  1  exception/eret flush of m2s and younger stages
- ws_allowin  in  1  ws accepts this cycle
- m2s_to_ws_valid  out  1  output bundle valid for ws
- m2s_pc  out  32  PC to ws
- m2s_rd  out  5  destination; also to forwarding
- m2s_reg_write  out  1  write enable; also to forwarding
- m2s_rf_wen  out  4  byte enables to ws
- m2s_wdata  out  32  write data (merged word)
- m2s_valid  out  1  live instruction in m2s (to forwarding)
- m2s_fwd_ok  out  1  m2s_wdata is final and may be bypassed

## Operation
- States: EMPTY, WAIT (load, response outstanding), FULL (result ready), DRAIN (flushed load, response still outstanding).
- m2s_allowin = (EMPTY) or (FULL and ws_allowin). It is 0 in WAIT, in DRAIN, and while reset is asserted.
- Accept when m1s_to_m2s_valid and m2s_allowin and not flush. All m1s_* fields are latched.
  - load_op != 0 → WAIT.
  - Otherwise → FULL, with wdata = m1s_result and rf_wen = 4'b1111.
  - If FULL hands off to ws in the same cycle, the new instruction replaces it.
- FULL with ws_allowin and no accept → EMPTY.
- WAIT with data_data_ok → FULL. The formatted data and rf_wen are latched (byte k = addr_lo):
  - lb/lbu: selected byte, sign-/zero-extended.
  - lh/lhu: halfword at addr_lo[1]*16, sign-/zero-extended.
  - lw: data_rdata. rf_wen 1111 for all five of these loads.
  - lwl, k=0/1/2/3: rf_wen 1000/1100/1110/1111. Top bytes come from data_rdata[8k+7:0], lower bytes from m1s_rt_val.
  - lwr, k=0/1/2/3: rf_wen 1111/0111/0011/0001. Low bytes come from data_rdata[31:8k], upper bytes from m1s_rt_val.
- m2s_reg_write = latched reg_write AND (WAIT or FULL). m2s_valid = WAIT or FULL. m2s_fwd_ok = FULL. m2s_to_ws_valid = FULL.
- Flush has priority over every other transition:
  - EMPTY/FULL → EMPTY; the incoming instruction is discarded.
  - WAIT → DRAIN, unless data_data_ok arrives in the same cycle, then → EMPTY.
- DRAIN: outputs invalid, allowin 0. data_data_ok (data discarded) → EMPTY.
- data_data_ok in EMPTY or FULL is a protocol violation; it is ignored and the state is unchanged.

## Timing
- Reset (async): state EMPTY. m2s_allowin, m2s_to_ws_valid, m2s_valid, m2s_fwd_ok, m2s_reg_write = 0. m2s_pc, m2s_rd, m2s_rf_wen, m2s_wdata = 0.
- Reset asserted mid-WAIT drops the instruction; the memory side is reset alongside it.
- After reset deasserts, m2s_allowin = 1 in the first cycle.
- All outputs are registered or decoded from state only. There is no combinational path from data_rdata/data_data_ok to outputs.
- m2s_allowin depends combinationally on ws_allowin only.
- Non-load: accepted at edge T → m2s_to_ws_valid high in cycle T+1.
- Load: response at edge R → FULL and result visible in cycle R+1. Minimum one WAIT cycle.
  - data_data_ok is never asserted in the acceptance cycle; the earliest response is the first WAIT cycle.
- Back-to-back non-loads with ws_allowin=1 sustain one instruction per cycle.
- Forwarding view: a load in WAIT has m2s_valid=1, m2s_fwd_ok=0, so the consumer must stall.

## Test plan
- Non-load stream: addu results 0x11, 0x22, 0x33 on rd 3/4/5 with ws_allowin=1 → three consecutive cycles of m2s_to_ws_valid with rf_wen 1111 and the matching wdata/rd.
- Loads with data_rdata=0x8899AABB:
  - lb addr_lo=1 → wdata 0xFFFFFFAA; lbu addr_lo=3 → 0x00000088; lh addr_lo=2 → 0xFFFF8899.
  - Each appears the cycle after data_data_ok, with m2s_fwd_ok=0 during WAIT.
- lwl/lwr with rt_val=0x11223344, data_rdata=0xAABBCCDD:
  - lwl k=1 → wdata 0xCCDD3344, rf_wen 1100.
  - lwr k=2 → 0x1122AABB, rf_wen 0011.
- Backpressure: FULL with ws_allowin=0 for 3 cycles → outputs stable, m2s_allowin=0. Releasing ws_allowin with a valid m1s input → handoff and accept in the same cycle.
- Flush during WAIT:
  - m2s_valid drops next cycle and the state is DRAIN.
  - A later data_data_ok is discarded and m2s_allowin returns to 1 the cycle after.
  - Flush coincident with data_data_ok → straight to EMPTY.
- Async reset asserted mid-FULL → all outputs 0 immediately. After release, m2s_allowin=1 and the first instruction completes normally.
